// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter: inhibit, request-to-send, 8 data bits + odd parity + stop, then ACK check.
// Latency: INHIBIT_CYCLES + 1 cycles to request-to-send, then paced by the device clock; done/error one cycle after the final event is seen.
// Backpressure: tx_ready is low from accept until done/error; tx_valid while not ready is dropped, never queued. Optional watchdog: PS2_TX_TIMEOUT_EN.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 12000,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_error,
    input  logic       PS2_CLK,
    input  logic       PS2_DATA,
    output logic       PS2_CLK_OE,
    output logic       PS2_DATA_OE
);

    localparam int INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_REQ,
        S_SEND,
        S_ACK,
        S_WAIT_IDLE
    } state_t;

    state_t           state;
    logic [INH_W-1:0] inh_cnt;
    logic [3:0]       bit_cnt;
    logic [3:0]       bit_cnt_nxt;
    logic [7:0]       data_q;
    logic             parity_q;

    logic clk_meta;
    logic clk_sync;
    logic clk_prev;
    logic data_meta;
    logic data_sync;
    logic fall;
    logic timeout_hit;

    // Two-flop synchronisers on both lines plus one history flop for clock edge detection; idle lines read high.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            clk_meta  <= 1'b1;
            clk_sync  <= 1'b1;
            clk_prev  <= 1'b1;
            data_meta <= 1'b1;
            data_sync <= 1'b1;
        end else begin
            clk_meta  <= PS2_CLK;
            clk_sync  <= clk_meta;
            clk_prev  <= clk_sync;
            data_meta <= PS2_DATA;
            data_sync <= data_meta;
        end
    end

    assign fall = clk_prev & ~clk_sync;

    // Bit counter saturates at 15 so a misbehaving device can never wrap it back into the data range.
    assign bit_cnt_nxt = (bit_cnt == 4'hF) ? bit_cnt : bit_cnt + 4'd1;

`ifdef PS2_TX_TIMEOUT_EN
    localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    logic [WD_W-1:0] wd_cnt;
    logic            in_watch;

    assign in_watch = (state == S_SEND) || (state == S_ACK) || (state == S_WAIT_IDLE);

    // Watchdog runs only while waiting on the device; it is held at zero elsewhere so it starts clean on entry to SEND.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wd_cnt <= '0;
        end else if (!in_watch) begin
            wd_cnt <= '0;
        end else begin
            wd_cnt <= wd_cnt + 1'b1;
        end
    end

    assign timeout_hit = in_watch && (wd_cnt == WD_LAST);
`else
    // No watchdog: a silent device holds the transfer until reset.
    assign timeout_hit = 1'b0;
`endif

    assign tx_busy = ~tx_ready;

    // Transfer sequencer with registered line enables and status pulses.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state       <= S_IDLE;
            inh_cnt     <= '0;
            bit_cnt     <= '0;
            data_q      <= '0;
            parity_q    <= 1'b0;
            tx_ready    <= 1'b1;
            tx_done     <= 1'b0;
            tx_error    <= 1'b0;
            PS2_CLK_OE  <= 1'b0;
            PS2_DATA_OE <= 1'b0;
        end else begin
            tx_done  <= 1'b0;
            tx_error <= 1'b0;
            case (state)
                S_IDLE: begin
                    PS2_CLK_OE  <= 1'b0;
                    PS2_DATA_OE <= 1'b0;
                    tx_ready    <= 1'b1;
                    if (tx_valid) begin
                        data_q     <= tx_data;
                        parity_q   <= ~^tx_data;
                        tx_ready   <= 1'b0;
                        PS2_CLK_OE <= 1'b1;
                        inh_cnt    <= '0;
                        state      <= S_INHIBIT;
                    end
                end

                S_INHIBIT: begin
                    if (inh_cnt == INH_LAST) begin
                        PS2_DATA_OE <= 1'b1;
                        state       <= S_REQ;
                    end else begin
                        inh_cnt <= inh_cnt + 1'b1;
                    end
                end

                S_REQ: begin
                    PS2_CLK_OE <= 1'b0;
                    bit_cnt    <= '0;
                    state      <= S_SEND;
                end

                S_SEND: begin
                    if (timeout_hit) begin
                        PS2_CLK_OE  <= 1'b0;
                        PS2_DATA_OE <= 1'b0;
                        tx_error    <= 1'b1;
                        tx_ready    <= 1'b1;
                        state       <= S_IDLE;
                    end else if (fall) begin
                        bit_cnt <= bit_cnt_nxt;
                        if (bit_cnt < 4'd8) begin
                            PS2_DATA_OE <= ~data_q[bit_cnt[2:0]];
                        end else if (bit_cnt == 4'd8) begin
                            PS2_DATA_OE <= ~parity_q;
                        end else begin
                            PS2_DATA_OE <= 1'b0;
                            state       <= S_ACK;
                        end
                    end
                end

                S_ACK: begin
                    // A device decision on this cycle takes priority over the watchdog.
                    if (fall) begin
                        if (!data_sync) begin
                            state <= S_WAIT_IDLE;
                        end else begin
                            tx_error <= 1'b1;
                            tx_ready <= 1'b1;
                            state    <= S_IDLE;
                        end
                    end else if (timeout_hit) begin
                        PS2_CLK_OE  <= 1'b0;
                        PS2_DATA_OE <= 1'b0;
                        tx_error    <= 1'b1;
                        tx_ready    <= 1'b1;
                        state       <= S_IDLE;
                    end
                end

                S_WAIT_IDLE: begin
                    if (clk_sync && data_sync) begin
                        tx_done  <= 1'b1;
                        tx_ready <= 1'b1;
                        state    <= S_IDLE;
                    end else if (timeout_hit) begin
                        PS2_CLK_OE  <= 1'b0;
                        PS2_DATA_OE <= 1'b0;
                        tx_error    <= 1'b1;
                        tx_ready    <= 1'b1;
                        state       <= S_IDLE;
                    end
                end

                default: begin
                    PS2_CLK_OE  <= 1'b0;
                    PS2_DATA_OE <= 1'b0;
                    tx_ready    <= 1'b1;
                    state       <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter. It sends one command byte (e.g. 0xF4 "enable data reporting", 0xFF "reset") to the mouse over the shared open-drain PS2_CLK/PS2_DATA lines.
- Sits beside ps2_mouse_handler. Top level drives each line low when the matching *_OE output is 1, otherwise the line floats high.
- tx_busy lets the top level gate off the receiver while a command is in flight.

Parameters:
- INHIBIT_CYCLES, 12000: CLK cycles PS2_CLK is held low before the request-to-send (120 us at 100 MHz, at least 100 us required).
- TIMEOUT_CYCLES, 2000000: watchdog limit from clock release to acknowledge (20 ms at 100 MHz).

Ports:
- CLK  in  1  system clock
- RST_N  in  1  asynchronous active-low reset
- tx_data  in  8  command byte
- tx_valid  in  1  request to send tx_data
- tx_ready  out  1  block idle, can accept a byte
- tx_busy  out  1  transfer in progress
- tx_done  out  1  one-cycle pulse: byte acknowledged by device
- tx_error  out  1  one-cycle pulse: NACK or timeout
- PS2_CLK  in  1  sampled PS/2 clock line
- PS2_DATA  in  1  sampled PS/2 data line
- PS2_CLK_OE  out  1  1 = pull PS/2 clock low
- PS2_DATA_OE  out  1  1 = pull PS/2 data low

Behaviour:
- Reset values (RST_N low, asynchronous): state IDLE, tx_ready=1, tx_busy=0, tx_done=0, tx_error=0, PS2_CLK_OE=0, PS2_DATA_OE=0, all counters 0.
- Input synchronisation:
  - PS2_CLK and PS2_DATA pass through 2-flop synchronisers, reset to 1.
  - fall = synced clock was 1 on the previous cycle and is 0 now.
- Handshake:
  - A byte is accepted on a cycle with tx_valid & tx_ready. tx_ready goes low the next cycle.
  - tx_data is latched. Parity is latched as odd parity: ~^tx_data.
  - tx_valid while tx_ready=0 is ignored, not queued.
  - tx_busy = ~tx_ready.
- IDLE: both OE=0. On accept, go to INHIBIT.
- INHIBIT: PS2_CLK_OE=1 for exactly INHIBIT_CYCLES cycles. On the last cycle, PS2_DATA_OE is set to 1 (start bit), then go to REQ.
- REQ: lasts one cycle with PS2_CLK_OE=1 and PS2_DATA_OE=1. Then PS2_CLK_OE=0, bit counter cleared, go to SEND.
- SEND: data changes only on fall. Bit counter increments on each fall.
  - Falls 1-8: PS2_DATA_OE = ~data[n-1], LSB first.
  - Fall 9: PS2_DATA_OE = ~parity.
  - Fall 10: PS2_DATA_OE = 0 (stop bit, line released). Go to ACK.
- ACK: on the next fall, sample synced PS2_DATA.
  - 0: go to WAIT_IDLE.
  - 1: pulse tx_error, go to IDLE.
- WAIT_IDLE: wait until synced clock=1 and data=1 on the same cycle. Then pulse tx_done and go to IDLE; tx_ready=1 in the same cycle as the tx_done pulse.
- tx_done and tx_error are never asserted in the same cycle.
- Reset mid-transfer: both OE drop to 0 immediately (asynchronously) and no pulse is emitted.
- Falls seen during IDLE or INHIBIT are ignored. The bit counter is 4 bits and saturates; it never wraps.

Optional Feature:
- Macro PS2_TX_TIMEOUT_EN.
- Defined: a watchdog counter clears on entry to SEND and counts every cycle through SEND, ACK and WAIT_IDLE. When it reaches TIMEOUT_CYCLES:
  - both OE=0 the next cycle,
  - tx_error pulses once,
  - state goes to IDLE.
  - If the timeout and an ACK/NACK decision land in the same cycle, the decision wins.
- Not defined: no watchdog logic. A silent device leaves the block in SEND/ACK until reset. tx_error only indicates NACK.

Test Plan:
- Send 0xF4 with a device model that ACKs:
  - PS2_CLK_OE high for 12000 cycles, then start bit.
  - Sampled bits 0,0,1,0,1,1,1,1, parity 0, stop 1.
  - Device ACK leads to exactly one tx_done pulse and tx_ready=1.
- Send 0xFF: data bits all 1, parity bit 1. Send 0x00: parity bit 1. Check both at the device sampling points (rising edges).
- Device returns data=1 at the ACK clock: one tx_error pulse, no tx_done, OE both 0, tx_ready=1.
- Pulse tx_valid again with 0x12 during SEND of 0xF4: the second byte is ignored and the transmitted byte stays 0xF4.
- Assert RST_N low at fall 5: PS2_CLK_OE and PS2_DATA_OE go 0 without waiting for CLK. After release, a new 0xF4 completes normally.
- With PS2_TX_TIMEOUT_EN and a device that never clocks: tx_error pulses TIMEOUT_CYCLES cycles after REQ exits, then IDLE. Without the macro the block stays busy.
